// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared constants for the timer lease scheduler.
//   - FSM state encodings (plain localparams so legacy code can compare them)
//   - default count width
//   - idx_onehot(): index to one-hot pulse vector (up to 16 requesters)
package timer_sched_pkg;

  localparam int CW_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [15:0] idx_onehot(input logic [3:0] idx);
    idx_onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// timer_sched_rr_arbiter: combinational round-robin pick.
// Ports:
//   req     in  NREQ  request mask
//   rr_ptr  in  IDW   first index to consider (must be < NREQ)
//   any     out 1     at least one request present
//   idx     out IDW   first set bit scanning upward from rr_ptr, mod NREQ
module timer_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int pos;
    pos = 0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: leases one one-shot `timing` unit to NREQ requesters.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req_valid/req_count         per-requester lease request and terminal count
//   req_cancel                  per-requester abort of a running lease
//   req_ack/req_done/
//   req_cancelled               one-cycle per-requester result pulses
//   busy, owner                 lease in progress and its holder
//   ro_trig_start/ro_trig_halt/
//   ro_mode/ro_termcount        control to the timing unit
//   rf_status, rf_int           running flag and terminal interrupt from timing
//
// state | meaning
// IDLE  | no lease; arbitrate among req_valid
// LOAD  | ack sent, count latched; start timer or finish a zero count
// RUN   | timer running; wait for interrupt, cancel or stalled timer
// DONE  | result pulse visible; advance round-robin pointer
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEFAULT,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*CW-1:0] req_count,
  input  logic [NREQ-1:0]   req_cancel,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_cancelled,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              ro_trig_start,
  output logic              ro_trig_halt,
  output logic              ro_mode,
  output logic [CW-1:0]     ro_termcount,
  input  logic              rf_status,
  input  logic              rf_int
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   termcount_q, termcount_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] canc_q, canc_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic            halt_q, halt_d;
  logic            run_first_q, run_first_d;
  logic            stat_low_q, stat_low_d;

  logic            arb_any;
  logic [IDW-1:0]  arb_idx;
  logic [NREQ-1:0] own_vec;

  timer_sched_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (arb_any),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    termcount_d = termcount_q;
    ack_d       = '0;
    done_d      = '0;
    canc_d      = '0;
    start_d     = 1'b0;
    halt_d      = 1'b0;
    run_first_d = run_first_q;
    stat_low_d  = stat_low_q;
    own_vec     = NREQ'(idx_onehot(4'(owner_q)));

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d     = ST_LOAD;
          owner_d     = arb_idx;
          termcount_d = req_count[int'(arb_idx)*CW +: CW];
          ack_d       = NREQ'(idx_onehot(4'(arb_idx)));
        end
      end
      ST_LOAD: begin
        if (termcount_q != '0) begin
          state_d     = ST_RUN;
          start_d     = 1'b1;
          run_first_d = 1'b1;
          stat_low_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          done_d  = own_vec;
        end
      end
      ST_RUN: begin
        run_first_d = 1'b0;
        if (rf_int) begin
          state_d = ST_DONE;
          done_d  = own_vec;
        end else if (|(req_cancel & own_vec)) begin
          state_d = ST_DONE;
          halt_d  = 1'b1;
          canc_d  = own_vec;
        end else if (!run_first_q && !rf_status && stat_low_q) begin
          // Timer stopped running without an interrupt: treat as aborted.
          // No halt is sent since the timer is already idle.
          state_d = ST_DONE;
          canc_d  = own_vec;
        end else begin
          // The first RUN sample precedes the timer seeing its start pulse.
          stat_low_d = !run_first_q && !rf_status;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      termcount_q <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      canc_q      <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      halt_q      <= 1'b0;
      run_first_q <= 1'b0;
      stat_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      termcount_q <= termcount_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      canc_q      <= canc_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      halt_q      <= halt_d;
      run_first_q <= run_first_d;
      stat_low_q  <= stat_low_d;
    end
  end

  assign req_ack       = ack_q;
  assign req_done      = done_q;
  assign req_cancelled = canc_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
  assign ro_trig_start = start_q;
  assign ro_trig_halt  = halt_q;
  assign ro_mode       = 1'b0;
  assign ro_termcount  = termcount_q;

endmodule
